// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus (NUM_REQ flattened requesters) plus the register-file write port.
// Requesters drive the req_* signals; the arbiter returns ready and drives the write port.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      w_en;
  logic [ADDR_W-1:0]         w_addr;
  logic [DATA_W-1:0]         w_data;
  logic [ID_W-1:0]           grant_id;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, w_en, w_addr, w_data, grant_id
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, w_en, w_addr, w_data, grant_id
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port; 1-cycle registered latency.
// Backpressure: only the winner sees req_ready (combinational); flush or reset holds all ready low.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  regfile_wb_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_grant_id;
  logic              r_w_en;
  logic [ADDR_W-1:0] r_w_addr;
  logic [DATA_W-1:0] r_w_data;

  logic [ID_W-1:0]   w_cand [NUM_REQ];
  logic [ID_W-1:0]   w_win_idx;
  logic              w_win_vld;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;

  // w_cand[k] is the k-th requester in priority order, starting just after the last winner
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cand
    assign w_cand[g] = ID_W'((int'(r_rr_ptr) + g + 1) % NUM_REQ);
  end

  // Scan lowest priority first so the highest-priority valid requester is written last
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[w_cand[k]]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_cand[k];
      end
    end
  end

  assign w_xfer     = w_win_vld & ~flush & rst_n;
  assign w_sel_addr = bus.req_addr[int'(w_win_idx) * ADDR_W +: ADDR_W];
  assign w_sel_data = bus.req_data[int'(w_win_idx) * DATA_W +: DATA_W];

  always_comb begin
    bus.req_ready = '0;
    if (w_xfer) begin
      bus.req_ready[w_win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= ID_W'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_w_en     <= 1'b0;
      r_w_addr   <= '0;
      r_w_data   <= '0;
    end else if (w_xfer) begin
      r_rr_ptr   <= w_win_idx;
      r_grant_id <= w_win_idx;
      r_w_en     <= (w_sel_addr != '0);
      r_w_addr   <= w_sel_addr;
      r_w_data   <= w_sel_data;
    end else begin
      r_w_en     <= 1'b0;
    end
  end

  assign bus.w_en     = r_w_en;
  assign bus.w_addr   = r_w_addr;
  assign bus.w_data   = r_w_data;
  assign bus.grant_id = r_grant_id;
endmodule
